ultrasonic_ranger: RTL and testbench

Drives an HC-SR04-style ultrasonic sensor and produces the 6-bit `distance` value that the data memory latches into its word 1 (memory-mapped sensor register). Each cycle of the block's state machine does three things: issue a trigger pulse, time the echo pulse, and convert its width to whole centimetres without a divider. It then presents the result as a held value plus a one-cycle strobe. A value of 0 means "no valid reading", which the memory ignores.

---
 rtl/ultrasonic_ranger.sv | 207 ++++++++++++++++++++
 tb/tb_ultrasonic_ranger.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_ranger.sv
// HC-SR04-style ultrasonic ranger: trigger, echo timing and divider-free cm conversion.
// Optional build macro RANGER_MEDIAN_EN: report the median of the last three results.
module ultrasonic_ranger #(
    parameter int CLK_FREQ_MHZ    = 50,
    parameter int TRIG_US         = 10,
    parameter int PERIOD_MS       = 60,
    parameter int ECHO_TIMEOUT_US = 25000,
    parameter int US_PER_CM       = 58
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic       echo,
    output logic       trig,
    output logic [5:0] distance,
    output logic       valid,
    output logic       busy
);
    localparam int TRIG_CYC   = TRIG_US * CLK_FREQ_MHZ;
    localparam int PERIOD_CYC = PERIOD_MS * 1000 * CLK_FREQ_MHZ;
    localparam int CM_CYC     = US_PER_CM * CLK_FREQ_MHZ;
    localparam int TO_CYC     = ECHO_TIMEOUT_US * CLK_FREQ_MHZ;
    localparam int CNT_MAX    = (TO_CYC > TRIG_CYC) ? TO_CYC : TRIG_CYC;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int PER_W      = $clog2(PERIOD_CYC + 1);
    localparam int PRE_W      = $clog2(CM_CYC + 1);

    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TO_CYC - 1);
    localparam logic [PER_W-1:0] PER_LAST  = PER_W'(PERIOD_CYC - 1);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CM_CYC - 1);
    localparam logic [5:0]       CM_SAT    = 6'd63;

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [5:0]         cm_q, cm_d;
    logic [PER_W-1:0]   per_q, per_d;
    logic               first_q, first_d;
    logic               trig_q, trig_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic [5:0]         distance_q, distance_d;
    logic               sync1_q, sync2_q, echo_prev_q;
    logic               echo_s, echo_rise_s, done_s;
    logic [5:0]         result_s;

`ifdef RANGER_MEDIAN_EN
    logic [5:0]         h0_q, h0_d, h1_q, h1_d;
    logic               hist_ok_q, hist_ok_d;

    function automatic logic [5:0] med3(input logic [5:0] a, input logic [5:0] b,
                                        input logic [5:0] c);
        if (a > b) begin
            med3 = (b > c) ? b : ((a > c) ? c : a);
        end else begin
            med3 = (a > c) ? a : ((b > c) ? c : b);
        end
    endfunction
`endif

    assign echo_s      = sync2_q;
    assign echo_rise_s = echo_s & ~echo_prev_q;

    // Next-state logic. The period counter saturates one short of PERIOD_CYC because
    // the launch decision is made the cycle before the trigger rises.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pre_d      = pre_q;
        cm_d       = cm_q;
        first_d    = first_q;
        distance_d = distance_q;
        valid_d    = 1'b0;
        done_s     = 1'b0;
        result_s   = 6'd0;
        per_d      = (per_q == PER_LAST) ? per_q : per_q + PER_W'(1);
`ifdef RANGER_MEDIAN_EN
        h0_d       = h0_q;
        h1_d       = h1_q;
        hist_ok_d  = hist_ok_q;
`endif
        case (state_q)
            IDLE: begin
                if (enable && (first_q || (per_q == PER_LAST))) begin
                    state_d = TRIG;
                    cnt_d   = '0;
                    per_d   = '0;
                    first_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    state_d = WAIT_ECHO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_ECHO: begin
                // The rise cycle itself already counts as one cycle of echo width.
                if (echo_rise_s) begin
                    state_d = MEASURE;
                    cnt_d   = CNT_W'(1);
                    pre_d   = PRE_W'(1);
                    cm_d    = 6'd0;
                end else if (cnt_q == TO_LAST) begin
                    done_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MEASURE: begin
                if (!echo_s) begin
                    done_s   = 1'b1;
                    result_s = (cm_q == 6'd0) ? 6'd1 : cm_q;
                end else if (cnt_q == TO_LAST) begin
                    done_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (pre_q == PRE_LAST) begin
                        pre_d = '0;
                        cm_d  = (cm_q == CM_SAT) ? cm_q : cm_q + 6'd1;
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (done_s) begin
            state_d = DONE;
            valid_d = 1'b1;
`ifdef RANGER_MEDIAN_EN
            distance_d = hist_ok_q ? med3(result_s, h0_q, h1_q) : result_s;
            h1_d       = hist_ok_q ? h0_q : result_s;
            h0_d       = result_s;
            hist_ok_d  = 1'b1;
`else
            distance_d = result_s;
`endif
        end else begin
            valid_d = 1'b0;
        end

        trig_d = (state_d == TRIG);
        busy_d = (state_d != IDLE);
    end

    // State, counters, synchroniser and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pre_q       <= '0;
            cm_q        <= 6'd0;
            per_q       <= '0;
            first_q     <= 1'b1;
            trig_q      <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            distance_q  <= 6'd0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            echo_prev_q <= 1'b0;
`ifdef RANGER_MEDIAN_EN
            h0_q        <= 6'd0;
            h1_q        <= 6'd0;
            hist_ok_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pre_q       <= pre_d;
            cm_q        <= cm_d;
            per_q       <= per_d;
            first_q     <= first_d;
            trig_q      <= trig_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            distance_q  <= distance_d;
            sync1_q     <= echo;
            sync2_q     <= sync1_q;
            echo_prev_q <= sync2_q;
`ifdef RANGER_MEDIAN_EN
            h0_q        <= h0_d;
            h1_q        <= h1_d;
            hist_ok_q   <= hist_ok_d;
`endif
        end
    end

    assign trig     = trig_q;
    assign distance = distance_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Scoreboard bench for ultrasonic_ranger at 1 MHz, 1 ms period, 5000-cycle timeout.
module tb_ultrasonic_ranger;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       enable = 1'b0;
    logic       echo = 1'b0;
    logic       trig;
    logic [5:0] distance;
    logic       valid;
    logic       busy;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int valid_hits = 0;
    int valid_at = 0;
    int dist_at_valid = 0;
    int exp_q[$];
    bit hv = 1'b0;
`ifdef RANGER_MEDIAN_EN
    int h0 = 0;
    int h1 = 0;
`endif

    ultrasonic_ranger #(
        .CLK_FREQ_MHZ(1), .TRIG_US(10), .PERIOD_MS(1),
        .ECHO_TIMEOUT_US(5000), .US_PER_CM(58)
    ) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .echo(echo),
        .trig(trig), .distance(distance), .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int med3(input int a, input int b, input int c);
        if (a > b) return (b > c) ? b : ((a > c) ? c : a);
        return (a > c) ? a : ((b > c) ? c : b);
    endfunction

    function automatic int raw_cm(input int w);
        int c;
        if (w == 0 || w >= 5000) return 0;
        c = w / 58;
        if (c > 63) c = 63;
        if (c == 0) c = 1;
        return c;
    endfunction

    task automatic tick();
        @(negedge clk);
        if (valid === 1'b1) begin
            valid_hits = valid_hits + 1;
            valid_at = cyc;
            dist_at_valid = int'(distance);
        end
    endtask

    task automatic wait_trig(input logic lvl, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 8000; n++) begin
            if (trig === lvl) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic push_expected(input int w);
        int r, e;
        r = raw_cm(w);
`ifdef RANGER_MEDIAN_EN
        if (!hv) begin
            h0 = r; h1 = r; hv = 1'b1; e = r;
        end else begin
            e = med3(r, h0, h1); h1 = h0; h0 = r;
        end
`else
        hv = 1'b1;
        e = r;
`endif
        exp_q.push_back(e);
    endtask

    // One full measurement: trigger, echo of width w (0 = none), result check.
    task automatic run_meas(input int w, input int dly, input bit drop_en, output int rise_at);
        int hi, fall_at, hits_before, e;
        bit ok;
        valid_hits = 0;
        rise_at = cyc;
        wait_trig(1'b1, ok);
        if (!ok) begin
            total_cnt++;
            $display("FAIL trig_rise w=%0d: no trigger within 8000 cycles, required one", w);
            return;
        end
        rise_at = cyc;
        hi = 0;
        while (trig === 1'b1 && hi < 100) begin
            hi++;
            tick();
        end
        fall_at = cyc;
        total_cnt++;
        if (hi !== 10) $display("FAIL trig_width w=%0d: got %0d cycles, required 10", w, hi);
        else pass_cnt++;
        repeat (dly) tick();
        push_expected(w);
        if (drop_en) enable = 1'b0;
        if (w > 0) begin
            echo = 1'b1;
            repeat (w) tick();
            echo = 1'b0;
        end
        hits_before = valid_hits;
        for (int n = 0; n < 7000 && valid_hits == 0; n++) tick();
        e = exp_q.pop_front();
        total_cnt++;
        if (valid_hits == 0) begin
            $display("FAIL valid_timeout w=%0d: no valid within bound, required one", w);
            return;
        end
        if (dist_at_valid !== e) $display("FAIL distance w=%0d: got %0d, required %0d", w, dist_at_valid, e);
        else pass_cnt++;
        if (hits_before == 0) begin
            tick();
            total_cnt++;
            if (valid !== 1'b0 || busy !== 1'b0)
                $display("FAIL after_done w=%0d: valid=%b busy=%b, required 0 0", w, valid, busy);
            else pass_cnt++;
        end
        total_cnt++;
        if (valid_hits !== 1) $display("FAIL valid_pulses w=%0d: got %0d, required 1", w, valid_hits);
        else pass_cnt++;
        if (w == 0) begin
            total_cnt++;
            if (valid_at - fall_at !== 5000)
                $display("FAIL no_echo_latency: got %0d cycles, required 5000", valid_at - fall_at);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; enable = 1'b0; echo = 1'b0;
        repeat (3) tick();
        total_cnt++;
        if ({trig, valid, busy} !== 3'b000 || distance !== 6'd0)
            $display("FAIL reset_state: trig=%b valid=%b busy=%b distance=%0d, required all 0", trig, valid, busy, distance);
        else pass_cnt++;
    endtask

    task automatic test_trigger_and_period();
        int r1, r2;
        resetn = 1'b1; enable = 1'b1;
        tick();
        total_cnt++;
        if (trig !== 1'b1) $display("FAIL first_trig_latency: trig=%b, required 1", trig);
        else pass_cnt++;
        run_meas(580, 20, 1'b0, r1);
        run_meas(30, 20, 1'b0, r2);
        total_cnt++;
        if (r2 - r1 !== 1000) $display("FAIL trig_period: got %0d cycles, required 1000", r2 - r1);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        int r;
        run_meas(4000, 5, 1'b0, r);
    endtask

    task automatic test_timeouts();
        int r;
        run_meas(0, 0, 1'b0, r);
        run_meas(6000, 10, 1'b1, r);
    endtask

    task automatic test_enable_low();
        int seen;
        seen = 0;
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (trig === 1'b1 || busy === 1'b1) seen++;
        end
        total_cnt++;
        if (seen !== 0) $display("FAIL enable_low: %0d active cycles, required 0", seen);
        else pass_cnt++;
        enable = 1'b1;
    endtask

    task automatic test_reset_mid_measure();
        int r;
        bit ok;
        run_meas(1160, 5, 1'b0, r);
        wait_trig(1'b1, ok);
        wait_trig(1'b0, ok);
        repeat (5) tick();
        echo = 1'b1;
        repeat (100) tick();
        resetn = 1'b0;
        #1;
        total_cnt++;
        if ({trig, valid, busy} !== 3'b000 || distance !== 6'd0)
            $display("FAIL reset_mid: trig=%b valid=%b busy=%b distance=%0d, required all 0", trig, valid, busy, distance);
        else pass_cnt++;
        echo = 1'b0;
        hv = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        tick();
        total_cnt++;
        if (trig !== 1'b1) $display("FAIL restart_trig: trig=%b, required 1", trig);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int r;
        run_meas(580, 3, 1'b0, r);
        run_meas(2320, 3, 1'b0, r);
        run_meas(696, 3, 1'b0, r);
    endtask

    initial begin
        test_reset();
        test_trigger_and_period();
        test_saturation();
        test_timeouts();
        test_enable_low();
        test_reset_mid_measure();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
